// File: rtl/commutation_sequencer.sv
// rtl/commutation_sequencer.sv - BLDC start-up / hall-synchronised commutation sequencer
// Drives step / force / power controls of a 6-step pattern generator through
// IDLE -> ALIGN -> RAMP (open loop) -> RUN (hall locked), with BRAKE and FAULT exits.
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_enable, i_brake_req, i_dir        run request, brake request, direction
//   i_power_target                      requested power (clamped to K_NSUBSTEPS-1)
//   i_sensor_valid, i_sensor_step       hall decoder event pulse and decoded step
//   o_step_trigger                      advance one substep
//   o_force_step_trigger/_value         force-load step value, o_force_substep always 0
//   o_step_reverse, o_brake, o_power    latched direction, brake request, slewed power
//   o_state, o_fault                    sequencer state, sticky stall fault
module commutation_sequencer #(
  parameter int K_NSUBSTEPS    = 10,
  parameter int K_PERIOD_W     = 16,
  parameter int K_ALIGN_CYCLES = 1000,
  parameter int K_RAMP_START   = 2000,
  parameter int K_RAMP_END     = 200,
  parameter int K_RAMP_DEC     = 10,
  parameter int K_PWR_SLEW     = 64,
  parameter int K_STALL        = 4095,
  localparam int PW = $clog2(K_NSUBSTEPS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_brake_req,
  input  logic          i_dir,
  input  logic [PW-1:0] i_power_target,
  input  logic          i_sensor_valid,
  input  logic [2:0]    i_sensor_step,
  output logic          o_step_trigger,
  output logic          o_force_step_trigger,
  output logic [2:0]    o_force_step_value,
  output logic [PW-1:0] o_force_substep,
  output logic          o_step_reverse,
  output logic          o_brake,
  output logic [PW-1:0] o_power,
  output logic [2:0]    o_state,
  output logic          o_fault
);

  localparam int AW = $clog2(K_ALIGN_CYCLES + 1);
  localparam int SW = (K_PWR_SLEW > 1) ? $clog2(K_PWR_SLEW) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_RAMP  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_BRAKE = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [PW-1:0]         SUB_LAST   = PW'(K_NSUBSTEPS - 1);
  localparam logic [AW-1:0]         ALIGN_LAST = AW'(K_ALIGN_CYCLES - 1);
  localparam logic [SW-1:0]         SLEW_LAST  = SW'(K_PWR_SLEW - 1);
  localparam logic [K_PERIOD_W-1:0] P_START    = K_PERIOD_W'(K_RAMP_START);
  localparam logic [K_PERIOD_W-1:0] P_END      = K_PERIOD_W'(K_RAMP_END);
  localparam logic [K_PERIOD_W-1:0] P_DEC      = K_PERIOD_W'(K_RAMP_DEC);
  localparam logic [K_PERIOD_W-1:0] P_ONE      = K_PERIOD_W'(1);
  localparam logic [K_PERIOD_W-1:0] P_STALL    = K_PERIOD_W'(K_STALL);

  logic [2:0]            state_q, state_d;
  logic                  dir_q, dir_d;
  logic [AW-1:0]         align_q, align_d;
  logic [K_PERIOD_W-1:0] period_q, period_d;
  logic [K_PERIOD_W-1:0] tmr_q, tmr_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [1:0]            lock_q, lock_d;
  logic [2:0]            last_q, last_d;
  logic [K_PERIOD_W-1:0] intv_q, intv_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         slew_q, slew_d;
  logic [PW-1:0]         power_q, power_d;
  logic                  step_q, step_d;
  logic                  force_q, force_d;
  logic [2:0]            fval_q, fval_d;
  logic                  brake_q, brake_d;
  logic                  fault_q, fault_d;

  logic                  sens_ok;
  logic                  tmr_hit;
  logic [2:0]            succ;
  logic [1:0]            lock_n;
  logic [PW-1:0]         tgt;
  logic [K_PERIOD_W-1:0] period_dec;
  logic [K_PERIOD_W-1:0] intv_inc;

  function automatic logic is_active(input logic [2:0] s);
    return (s == S_ALIGN) || (s == S_RAMP) || (s == S_RUN);
  endfunction

  // Hall codes 6/7 are treated as if no event happened.
  assign sens_ok    = i_sensor_valid && (i_sensor_step < 3'd6);
  assign tmr_hit    = (tmr_q >= period_q - P_ONE);
  assign tgt        = (i_power_target > SUB_LAST) ? SUB_LAST : i_power_target;
  assign period_dec = (int'(period_q) - K_RAMP_DEC > K_RAMP_END) ? period_q - P_DEC : P_END;
  // Interval value including this cycle's prescaler wrap, so a sensor event
  // sees the full elapsed count rather than one less.
  assign intv_inc   = ((presc_q == SUB_LAST) && (intv_q != '1)) ? intv_q + P_ONE : intv_q;
  assign succ       = dir_q ? ((last_q == 3'd0) ? 3'd5 : last_q - 3'd1)
                            : ((last_q == 3'd5) ? 3'd0 : last_q + 3'd1);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    align_d  = align_q;
    period_d = period_q;
    tmr_d    = tmr_q;
    pcnt_d   = pcnt_q;
    lock_d   = lock_q;
    last_d   = last_q;
    intv_d   = intv_q;
    presc_d  = presc_q;
    slew_d   = slew_q;
    power_d  = power_q;
    step_d   = 1'b0;
    force_d  = 1'b0;
    fval_d   = fval_q;
    brake_d  = 1'b0;
    fault_d  = fault_q;
    lock_n   = lock_q;

    if (state_q == S_IDLE) begin
      if (i_enable && !i_brake_req) begin
        state_d = S_ALIGN;
        dir_d   = i_dir;
        force_d = 1'b1;
        fval_d  = 3'd0;
        align_d = '0;
      end
    end else if (i_brake_req) begin
      state_d = S_BRAKE;
    end else if (!i_enable) begin
      state_d = S_IDLE;
    end else if ((state_q == S_RUN) && (intv_q >= P_STALL)) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_ALIGN: begin
          if (align_q == ALIGN_LAST) begin
            state_d  = S_RAMP;
            period_d = P_START;
            tmr_d    = '0;
            pcnt_d   = '0;
            lock_d   = 2'd0;
          end else begin
            align_d = align_q + 1'b1;
          end
        end
        S_RAMP: begin
          // lock_q counts the length of the current successor chain (0 = none yet).
          if (sens_ok) begin
            if ((lock_q != 2'd0) && (i_sensor_step == succ))
              lock_n = (lock_q == 2'd3) ? 2'd3 : lock_q + 2'd1;
            else
              lock_n = 2'd1;
            lock_d = lock_n;
            last_d = i_sensor_step;
          end
          if (sens_ok && (lock_n == 2'd3) && (period_q == P_END)) begin
            state_d = S_RUN;
            force_d = 1'b1;
            fval_d  = i_sensor_step;
            tmr_d   = '0;
            pcnt_d  = '0;
            intv_d  = '0;
            presc_d = '0;
          end else if (tmr_hit) begin
            step_d = 1'b1;
            tmr_d  = '0;
            if (pcnt_q == SUB_LAST) begin
              pcnt_d   = '0;
              period_d = period_dec;
            end else begin
              pcnt_d = pcnt_q + 1'b1;
            end
          end else begin
            tmr_d = tmr_q + P_ONE;
          end
        end
        S_RUN: begin
          if (sens_ok) begin
            force_d  = 1'b1;
            fval_d   = i_sensor_step;
            period_d = (intv_inc == '0) ? P_ONE : intv_inc;
            tmr_d    = '0;
            pcnt_d   = '0;
            intv_d   = '0;
            presc_d  = '0;
          end else begin
            intv_d  = intv_inc;
            presc_d = (presc_q == SUB_LAST) ? '0 : presc_q + 1'b1;
            if (tmr_hit) begin
              tmr_d = '0;
              // The last substep of a step is left to the next hall event.
              if (pcnt_q != SUB_LAST) begin
                step_d = 1'b1;
                pcnt_d = pcnt_q + 1'b1;
              end
            end else begin
              tmr_d = tmr_q + P_ONE;
            end
          end
        end
        default: ;
      endcase
    end

    if ((state_d == S_BRAKE) || (state_d == S_FAULT))
      brake_d = 1'b1;
    if (state_d == S_FAULT)
      fault_d = 1'b1;
    else if (state_d == S_IDLE)
      fault_d = 1'b0;

    // Slew runs only while staying inside the powered states; any exit zeroes power.
    if (is_active(state_q) && is_active(state_d)) begin
      if (slew_q == SLEW_LAST) begin
        slew_d = '0;
        if (power_q < tgt)
          power_d = power_q + 1'b1;
        else if (power_q > tgt)
          power_d = power_q - 1'b1;
      end else begin
        slew_d = slew_q + 1'b1;
      end
    end else begin
      slew_d  = '0;
      power_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      align_q  <= '0;
      period_q <= P_START;
      tmr_q    <= '0;
      pcnt_q   <= '0;
      lock_q   <= 2'd0;
      last_q   <= 3'd0;
      intv_q   <= '0;
      presc_q  <= '0;
      slew_q   <= '0;
      power_q  <= '0;
      step_q   <= 1'b0;
      force_q  <= 1'b0;
      fval_q   <= 3'd0;
      brake_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      align_q  <= align_d;
      period_q <= period_d;
      tmr_q    <= tmr_d;
      pcnt_q   <= pcnt_d;
      lock_q   <= lock_d;
      last_q   <= last_d;
      intv_q   <= intv_d;
      presc_q  <= presc_d;
      slew_q   <= slew_d;
      power_q  <= power_d;
      step_q   <= step_d;
      force_q  <= force_d;
      fval_q   <= fval_d;
      brake_q  <= brake_d;
      fault_q  <= fault_d;
    end
  end

  assign o_step_trigger       = step_q;
  assign o_force_step_trigger = force_q;
  assign o_force_step_value   = fval_q;
  assign o_force_substep      = '0;
  assign o_step_reverse       = dir_q;
  assign o_brake              = brake_q;
  assign o_power              = power_q;
  assign o_state              = state_q;
  assign o_fault              = fault_q;

endmodule

// File: tb/tb_commutation_sequencer.sv
// tb/tb_commutation_sequencer.sv - self-checking bench for commutation_sequencer
module tb_commutation_sequencer;

  localparam int NS    = 10;
  localparam int PW    = $clog2(NS);
  localparam int ALIGN = 40;
  localparam int RS    = 95;
  localparam int RE    = 30;
  localparam int RD    = 10;
  localparam int SLEW  = 4;
  localparam int STALL = 150;

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_brake_req = 1'b0;
  logic          i_dir = 1'b0;
  logic [PW-1:0] i_power_target = '0;
  logic          i_sensor_valid = 1'b0;
  logic [2:0]    i_sensor_step = 3'd0;
  logic          o_step_trigger;
  logic          o_force_step_trigger;
  logic [2:0]    o_force_step_value;
  logic [PW-1:0] o_force_substep;
  logic          o_step_reverse;
  logic          o_brake;
  logic [PW-1:0] o_power;
  logic [2:0]    o_state;
  logic          o_fault;

  commutation_sequencer #(
    .K_NSUBSTEPS(NS), .K_PERIOD_W(16), .K_ALIGN_CYCLES(ALIGN), .K_RAMP_START(RS),
    .K_RAMP_END(RE), .K_RAMP_DEC(RD), .K_PWR_SLEW(SLEW), .K_STALL(STALL)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_brake_req(i_brake_req),
    .i_dir(i_dir), .i_power_target(i_power_target), .i_sensor_valid(i_sensor_valid),
    .i_sensor_step(i_sensor_step), .o_step_trigger(o_step_trigger),
    .o_force_step_trigger(o_force_step_trigger), .o_force_step_value(o_force_step_value),
    .o_force_substep(o_force_substep), .o_step_reverse(o_step_reverse), .o_brake(o_brake),
    .o_power(o_power), .o_state(o_state), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] step;
    int         exp_state;
    int         exp_force;
    int         exp_fval;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int overlap = 0;
  int spurious = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (o_step_trigger && o_force_step_trigger) overlap++;
  endtask

  task automatic event_tick(input logic [2:0] s);
    i_sensor_valid = 1'b1;
    i_sensor_step  = s;
    tick();
    i_sensor_valid = 1'b0;
  endtask

  // One RUN segment of k clocks ending in a sensor event carrying s.
  // p > 0: pulses must land at multiples of p, at most NS-1 of them, none on the event.
  task automatic run_seg(input int k, input logic [2:0] s, input int p);
    int start;
    int npulse;
    int nexp;
    start  = cyc;
    npulse = 0;
    nexp   = 0;
    if (p > 0) nexp = ((k - 1) / p < NS - 1) ? (k - 1) / p : NS - 1;
    for (int j = 1; j < k; j++) begin
      if (($urandom & 15) == 0) begin
        i_sensor_valid = 1'b1;
        i_sensor_step  = 3'd6 + 3'($urandom & 1);
      end
      tick();
      i_sensor_valid = 1'b0;
      if (o_force_step_trigger) spurious++;
      if (o_step_trigger) begin
        npulse++;
        if (p > 0) check("run_pulse_time", cyc - start, npulse * p);
      end
    end
    event_tick(s);
    check("run_force", int'(o_force_step_trigger), 1);
    check("run_force_val", int'(o_force_step_value), int'(s));
    check("run_step_dropped", int'(o_step_trigger), 0);
    if (p > 0) check("run_pulse_count", npulse, nexp);
  endtask

  initial begin
    vec_t tbl [6];
    int   e0, r0, exp_t, p, got, k, nf;
    logic [2:0] s;

    tbl[0] = '{3'd2, 2, 0, 0};
    tbl[1] = '{3'd4, 2, 0, 0};
    tbl[2] = '{3'd7, 2, 0, 0};
    tbl[3] = '{3'd5, 2, 0, 0};
    tbl[4] = '{3'd6, 2, 0, 0};
    tbl[5] = '{3'd0, 3, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", int'(o_state), 0);
    check("rst_power", int'(o_power), 0);
    check("rst_brake", int'(o_brake), 0);
    check("rst_fault", int'(o_fault), 0);
    check("rst_step", int'(o_step_trigger), 0);
    check("rst_force", int'(o_force_step_trigger), 0);
    check("rst_rev", int'(o_step_reverse), 0);
    i_rst_n = 1'b1;
    tick();

    // Brake request blocks start-up from IDLE
    i_enable = 1'b1;
    i_brake_req = 1'b1;
    i_power_target = 4'd5;
    tick();
    check("idle_brake_hold", int'(o_state), 0);
    check("idle_brake_noforce", int'(o_force_step_trigger), 0);
    i_brake_req = 1'b0;

    // Start-up: force 0, ALIGN for ALIGN clocks, power slews one per SLEW clocks
    tick();
    e0 = cyc;
    check("align_force", int'(o_force_step_trigger), 1);
    check("align_fval", int'(o_force_step_value), 0);
    check("align_state", int'(o_state), 1);
    check("align_power0", int'(o_power), 0);
    for (int n = 1; n <= ALIGN; n++) begin
      tick();
      check("align_state_n", int'(o_state), (n < ALIGN) ? 1 : 2);
      check("align_power_n", int'(o_power), (n / SLEW < 5) ? n / SLEW : 5);
      if (o_step_trigger) check("align_no_step", 1, 0);
    end
    r0 = cyc;

    // Open-loop ramp: period shrinks by RD every NS pulses, floored at RE
    exp_t = r0;
    p = RS;
    for (int i = 0; i < 8 * NS; i++) begin
      exp_t += p;
      if ((i + 1) % NS == 0) p = (p - RD > RE) ? p - RD : RE;
      got = 0;
      while (cyc < exp_t + 2 && got == 0) begin
        tick();
        if (o_step_trigger) got = 1;
      end
      check("ramp_pulse_time", (got != 0) ? cyc : -1, exp_t);
    end

    // Lock attempts at the floor period
    foreach (tbl[i]) begin
      repeat (3) tick();
      event_tick(tbl[i].step);
      check("lock_state", int'(o_state), tbl[i].exp_state);
      check("lock_force", int'(o_force_step_trigger), tbl[i].exp_force);
      if (tbl[i].exp_force != 0) check("lock_fval", int'(o_force_step_value), tbl[i].exp_fval);
    end

    // RUN: hall-synchronised substep timing
    i_power_target = 4'd15;
    run_seg(1000, 3'd1, -1);
    run_seg(1000, 3'd2, 100);
    run_seg(550, 3'd3, 100);
    run_seg(110, 3'd4, 55);
    p = 11;
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(5, 400);
      s = 3'($urandom_range(0, 5));
      run_seg(k, s, p);
      p = (k / NS > 1) ? k / NS : 1;
    end
    check("run_power_clamp", int'(o_power), NS - 1);
    check("run_state", int'(o_state), 3);

    // Stall
    nf = -1;
    for (int n = 1; n <= NS * STALL + 10 && nf < 0; n++) begin
      tick();
      if (n == NS * STALL - 5) check("stall_not_yet", int'(o_state), 3);
      if (o_state == 3'd5) nf = n;
    end
    check("stall_window", int'(nf >= NS * STALL - 4 && nf <= NS * STALL + 5), 1);
    check("fault_state", int'(o_state), 5);
    check("fault_flag", int'(o_fault), 1);
    check("fault_brake", int'(o_brake), 1);
    check("fault_power", int'(o_power), 0);
    i_enable = 1'b0;
    tick();
    check("fault_exit_state", int'(o_state), 0);
    check("fault_exit_flag", int'(o_fault), 0);
    check("fault_exit_brake", int'(o_brake), 0);

    // Brake during RAMP
    i_enable = 1'b1;
    i_power_target = 4'd3;
    repeat (ALIGN + 30) tick();
    check("brk_pre_state", int'(o_state), 2);
    check("brk_pre_power", int'(o_power), 3);
    i_brake_req = 1'b1;
    tick();
    check("brk_state", int'(o_state), 4);
    check("brk_brake", int'(o_brake), 1);
    check("brk_power", int'(o_power), 0);
    got = 0;
    for (int n = 0; n < 120; n++) begin
      tick();
      if (o_step_trigger || o_force_step_trigger) got++;
    end
    check("brk_no_pulses", got, 0);
    i_brake_req = 1'b0;
    repeat (5) tick();
    check("brk_hold_enable", int'(o_state), 4);
    i_brake_req = 1'b1;
    i_enable = 1'b0;
    tick();
    check("brk_prio", int'(o_state), 4);
    i_brake_req = 1'b0;
    tick();
    check("brk_exit_state", int'(o_state), 0);
    check("brk_exit_brake", int'(o_brake), 0);

    // Reverse start-up, lock on 3,2,1, then async reset mid-RUN
    i_dir = 1'b1;
    i_enable = 1'b1;
    tick();
    check("rev_latched", int'(o_step_reverse), 1);
    i_dir = 1'b0;
    repeat (ALIGN + 4700) tick();
    event_tick(3'd3);
    repeat (3) tick();
    event_tick(3'd2);
    repeat (3) tick();
    event_tick(3'd1);
    check("rev_lock_state", int'(o_state), 3);
    check("rev_lock_fval", int'(o_force_step_value), 1);
    check("rev_hold_dir", int'(o_step_reverse), 1);
    repeat (5) tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_state", int'(o_state), 0);
    check("arst_power", int'(o_power), 0);
    check("arst_rev", int'(o_step_reverse), 0);
    check("arst_brake", int'(o_brake), 0);
    check("arst_fault", int'(o_fault), 0);

    check("no_step_force_overlap", overlap, 0);
    check("no_spurious_force", spurious, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
